// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/load-unit requesters and the register-file arbiter.
// The master side drives requests; the slave side is the arbiter.
interface regfile_wb_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [3:0]  a_rd;
  logic [15:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [3:0]  b_rd;
  logic [15:0] b_data;
  logic        reg_write;
  logic [3:0]  wr_rd;
  logic [15:0] wr_data;
  logic [15:0] pending_mask;
  logic [7:0]  stall_cnt;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, reg_write, wr_rd, wr_data, pending_mask, stall_cnt
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, reg_write, wr_rd, wr_data, pending_mask, stall_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter with one-entry buffers feeding a single register-file write port.
// Oldest buffered write retires first; simultaneous arrivals are resolved by a round-robin pointer.
module regfile_wb_arbiter (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

  logic        a_full_r, b_full_r;
  logic        a_tag_r, b_tag_r;
  logic [3:0]  a_rd_r, b_rd_r;
  logic [15:0] a_data_r, b_data_r;
  logic        ptr_r;
  logic [7:0]  stall_cnt_r;

  logic        gnt_a_s, gnt_b_s;
  logic        a_ready_s, b_ready_s;
  logic        a_load_s, b_load_s;
  logic        stall_s;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    onehot16 = 16'd1 << idx;
  endfunction

  // Grant selection; a set tag means that buffer loaded while the other was already waiting.
  always_comb begin
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    case ({a_full_r, b_full_r})
      2'b10: gnt_a_s = 1'b1;
      2'b01: gnt_b_s = 1'b1;
      2'b11: begin
        if (a_tag_r != b_tag_r) begin
          gnt_a_s = b_tag_r;
          gnt_b_s = a_tag_r;
        end else begin
          gnt_a_s = (ptr_r == PTR_A);
          gnt_b_s = (ptr_r == PTR_B);
        end
      end
      default: begin
        gnt_a_s = 1'b0;
        gnt_b_s = 1'b0;
      end
    endcase
  end

  // Handshake: ready ignores valid; rd=0 transfers complete but never load.
  always_comb begin
    a_ready_s = ~a_full_r | gnt_a_s;
    b_ready_s = ~b_full_r | gnt_b_s;
    a_load_s  = bus.a_valid & a_ready_s & (bus.a_rd != 4'd0);
    b_load_s  = bus.b_valid & b_ready_s & (bus.b_rd != 4'd0);
    stall_s   = (bus.a_valid & ~a_ready_s) | (bus.b_valid & ~b_ready_s);
  end

  // Buffer A
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_full_r <= 1'b0;
      a_tag_r  <= 1'b0;
      a_rd_r   <= 4'd0;
      a_data_r <= 16'd0;
    end else if (a_load_s) begin
      a_full_r <= 1'b1;
      a_tag_r  <= b_full_r & ~gnt_b_s;
      a_rd_r   <= bus.a_rd;
      a_data_r <= bus.a_data;
    end else if (gnt_a_s) begin
      a_full_r <= 1'b0;
      a_tag_r  <= 1'b0;
    end else if (gnt_b_s) begin
      a_tag_r  <= 1'b0;
    end
  end

  // Buffer B
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_full_r <= 1'b0;
      b_tag_r  <= 1'b0;
      b_rd_r   <= 4'd0;
      b_data_r <= 16'd0;
    end else if (b_load_s) begin
      b_full_r <= 1'b1;
      b_tag_r  <= a_full_r & ~gnt_a_s;
      b_rd_r   <= bus.b_rd;
      b_data_r <= bus.b_data;
    end else if (gnt_b_s) begin
      b_full_r <= 1'b0;
      b_tag_r  <= 1'b0;
    end else if (gnt_a_s) begin
      b_tag_r  <= 1'b0;
    end
  end

  // Priority pointer moves to the requester that lost each grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= PTR_A;
    end else if (gnt_a_s) begin
      ptr_r <= PTR_B;
    end else if (gnt_b_s) begin
      ptr_r <= PTR_A;
    end
  end

  // Saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 8'd0;
    end else if (stall_s && (stall_cnt_r != 8'hFF)) begin
      stall_cnt_r <= stall_cnt_r + 8'd1;
    end
  end

  // Write port and status outputs
  always_comb begin
    bus.a_ready   = a_ready_s;
    bus.b_ready   = b_ready_s;
    bus.stall_cnt = stall_cnt_r;
    bus.reg_write = gnt_a_s | gnt_b_s;
    if (gnt_a_s) begin
      bus.wr_rd   = a_rd_r;
      bus.wr_data = a_data_r;
    end else if (gnt_b_s) begin
      bus.wr_rd   = b_rd_r;
      bus.wr_data = b_data_r;
    end else begin
      bus.wr_rd   = 4'd0;
      bus.wr_data = 16'd0;
    end
    bus.pending_mask = ((a_full_r ? onehot16(a_rd_r) : 16'd0) |
                        (b_full_r ? onehot16(b_rd_r) : 16'd0)) & 16'hFFFE;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a small register-file model on the write port.
module tb_regfile_wb_arbiter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   wr_cnt;
  int   wr_snap;
  logic [15:0] rf [16];

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.reg_write) begin
      rf[bus.wr_rd] <= bus.wr_data;
      wr_cnt        <= wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    wr_cnt   = 0;
    rst_n    = 1'b0;
    bus.a_valid = 1'b0; bus.a_rd = 4'd0; bus.a_data = 16'd0;
    bus.b_valid = 1'b0; bus.b_rd = 4'd0; bus.b_data = 16'd0;

    // Reset state
    tick(); tick();
    chk("rst_reg_write", 32'(bus.reg_write), 32'd0);
    chk("rst_wr_rd", 32'(bus.wr_rd), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk("rst_pending", 32'(bus.pending_mask), 32'd0);
    chk("rst_ready", 32'({bus.a_ready, bus.b_ready}), 32'd3);
    chk("rst_stall", 32'(bus.stall_cnt), 32'd0);
    rst_n = 1'b1;

    // Lone A streaming back-to-back
    bus.a_valid = 1'b1; bus.a_rd = 4'd3; bus.a_data = 16'h1111;
    chk("s1_a_ready0", 32'(bus.a_ready), 32'd1);
    tick();
    chk("s1_w1", 32'({bus.reg_write, bus.wr_rd, bus.wr_data}), 32'h13_1111);
    chk("s1_pending", 32'(bus.pending_mask), 32'h0008);
    chk("s1_a_ready1", 32'(bus.a_ready), 32'd1);
    bus.a_rd = 4'd4; bus.a_data = 16'h2222;
    tick();
    chk("s1_w2", 32'({bus.reg_write, bus.wr_rd, bus.wr_data}), 32'h14_2222);
    chk("s1_a_ready2", 32'(bus.a_ready), 32'd1);
    bus.a_valid = 1'b0;
    tick();
    chk("s1_idle", 32'({bus.reg_write, bus.wr_rd, bus.wr_data}), 32'd0);
    chk("s1_pending_idle", 32'(bus.pending_mask), 32'd0);
    chk("s1_stall", 32'(bus.stall_cnt), 32'd0);
    chk("s1_r3", 32'(rf[3]), 32'h1111);
    chk("s1_r4", 32'(rf[4]), 32'h2222);

    // Same-edge arrival after reset: pointer favours A
    reset_pulse();
    bus.a_valid = 1'b1; bus.a_rd = 4'd5; bus.a_data = 16'hAAAA;
    bus.b_valid = 1'b1; bus.b_rd = 4'd5; bus.b_data = 16'hBBBB;
    tick();
    bus.a_valid = 1'b0;
    chk("s2_first", 32'({bus.reg_write, bus.wr_rd, bus.wr_data}), 32'h15_AAAA);
    chk("s2_b_ready_lo", 32'(bus.b_ready), 32'd0);
    chk("s2_pending", 32'(bus.pending_mask), 32'h0020);
    tick();
    bus.b_valid = 1'b0;
    chk("s2_second", 32'({bus.reg_write, bus.wr_rd, bus.wr_data}), 32'h15_BBBB);
    chk("s2_b_ready_hi", 32'(bus.b_ready), 32'd1);
    chk("s2_stall", 32'(bus.stall_cnt), 32'd1);
    tick();
    chk("s2_idle", 32'(bus.reg_write), 32'd0);
    chk("s2_r5", 32'(rf[5]), 32'hBBBB);
    chk("s2_stall_hold", 32'(bus.stall_cnt), 32'd1);

    // B buffered one edge before A, both targeting r7: B must retire first
    reset_pulse();
    bus.a_valid = 1'b1; bus.a_rd = 4'd2; bus.a_data = 16'h0A02;
    bus.b_valid = 1'b1; bus.b_rd = 4'd7; bus.b_data = 16'h0B07;
    tick();
    bus.a_rd = 4'd7; bus.a_data = 16'h0A07;
    bus.b_valid = 1'b0;
    chk("s3_w_r2", 32'({bus.reg_write, bus.wr_rd, bus.wr_data}), 32'h12_0A02);
    chk("s3_pending0", 32'(bus.pending_mask), 32'h0084);
    chk("s3_b_held", 32'(bus.b_ready), 32'd0);
    tick();
    bus.a_valid = 1'b0;
    chk("s3_b_first", 32'({bus.reg_write, bus.wr_rd, bus.wr_data}), 32'h17_0B07);
    chk("s3_pending1", 32'(bus.pending_mask), 32'h0080);
    tick();
    chk("s3_a_second", 32'({bus.reg_write, bus.wr_rd, bus.wr_data}), 32'h17_0A07);
    chk("s3_pending2", 32'(bus.pending_mask), 32'h0080);
    tick();
    chk("s3_idle", 32'(bus.reg_write), 32'd0);
    chk("s3_pending3", 32'(bus.pending_mask), 32'd0);
    chk("s3_r7", 32'(rf[7]), 32'h0A07);

    // rd=0 on both ports: accepted and discarded
    wr_snap = wr_cnt;
    bus.a_valid = 1'b1; bus.a_rd = 4'd0; bus.a_data = 16'h1234;
    bus.b_valid = 1'b1; bus.b_rd = 4'd0; bus.b_data = 16'h5678;
    chk("s4_ready", 32'({bus.a_ready, bus.b_ready}), 32'd3);
    tick();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    chk("s4_no_write", 32'(bus.reg_write), 32'd0);
    chk("s4_pending", 32'(bus.pending_mask), 32'd0);
    chk("s4_ready_after", 32'({bus.a_ready, bus.b_ready}), 32'd3);
    tick();
    chk("s4_wr_cnt", 32'(wr_cnt - wr_snap), 32'd0);

    // Both ports saturating the write port for 300 cycles
    reset_pulse();
    bus.a_valid = 1'b1; bus.a_rd = 4'd1; bus.a_data = 16'h00A1;
    bus.b_valid = 1'b1; bus.b_rd = 4'd2; bus.b_data = 16'h00B2;
    tick();
    for (int i = 0; i < 300; i++) begin
      chk("s5_alt", 32'({bus.reg_write, bus.wr_rd}), (i % 2 == 0) ? 32'h11 : 32'h12);
      tick();
    end
    chk("s5_stall_sat", 32'(bus.stall_cnt), 32'd255);
    tick();
    chk("s5_stall_nowrap", 32'(bus.stall_cnt), 32'd255);
    chk("s5_pending", 32'(bus.pending_mask), 32'h0006);

    // Async reset with both buffers full
    #2;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("s6_reg_write", 32'(bus.reg_write), 32'd0);
    chk("s6_pending", 32'(bus.pending_mask), 32'd0);
    chk("s6_ready", 32'({bus.a_ready, bus.b_ready}), 32'd3);
    chk("s6_stall", 32'(bus.stall_cnt), 32'd0);
    wr_snap = wr_cnt;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("s6_no_writes", 32'(wr_cnt - wr_snap), 32'd0);
    chk("s6_idle", 32'({bus.reg_write, bus.wr_rd, bus.wr_data}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
